// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check controller:
//   - state_t              : controller FSM state encoding
//   - ADDR_ID / ADDR_TS    : word-select values on avm_address
//   - DEFAULT_EXPECTED_ID  : default required value of word 0
//   - DEFAULT_EXPECTED_TS  : default required value of word 1
//   - words_match()        : compare both captured words against expectations
//   - is_read_state()      : true in the states that drive avm_read
// -----------------------------------------------------------------------------
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_RD_TS  = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_CHECK  = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    localparam logic        ADDR_ID             = 1'b0;
    localparam logic        ADDR_TS             = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1428568153;

    function automatic logic words_match(
        input logic [31:0] id_word,
        input logic [31:0] ts_word,
        input logic [31:0] exp_id,
        input logic [31:0] exp_ts
    );
        return (id_word == exp_id) && (ts_word == exp_ts);
    endfunction

    function automatic logic is_read_state(input state_t st);
        return (st == ST_RD_ID) || (st == ST_RD_TS);
    endfunction

endpackage

// File: rtl/sysid_check_ctrl_avm_read_timer.sv
// -----------------------------------------------------------------------------
// avm_read_timer
// One 16-bit cycle counter shared between the stall timeout and the read
// latency wait of an Avalon-MM read sequencer. The owner decides which of the
// two outputs is meaningful in its current state.
// Parameters:
//   TIMEOUT_CYCLES : stall cycles allowed before expired (1..65535)
//   READ_LATENCY   : accepted-read to readdata-valid distance (0..3)
// Ports:
//   clock    in  : system clock
//   reset    in  : asynchronous active-high reset
//   clear    in  : zero the counter (wins over run)
//   run      in  : advance the counter this cycle
//   expired  out : this running cycle is the TIMEOUT_CYCLES-th one
//   lat_done out : counter sits on the last latency cycle
// -----------------------------------------------------------------------------
module avm_read_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned READ_LATENCY   = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired,
    output logic lat_done
);

    // Compare against "limit minus one" so the flag is raised in the cycle in
    // which the counter would reach the limit, letting the owner act on that
    // very edge.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [15:0] LATENCY_LAST = (READ_LATENCY == 32'd0) ? 16'd0
                                         : 16'(READ_LATENCY - 32'd1);

    logic [15:0] count_r;

    // Cycle counter: clear has priority, otherwise count while running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (run) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired  = run && (count_r == TIMEOUT_LAST);
    assign lat_done = (count_r == LATENCY_LAST);

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp), compares both words with build-time constants
// and reports pass / timeout status. A mismatch triggers up to MAX_RETRIES
// further full passes; a read stalled for TIMEOUT_CYCLES aborts the check.
//
// Optional feature macro: SYSID_CHECK_AUTOSTART_EN
//   defined   : a one-shot launches a check on the first edge after reset
//   undefined : checks start only on the start pulse
//
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous active-high reset
//   start           in   one-cycle pulse, honoured only while idle
//   avm_address     out  word select (0 = ID, 1 = timestamp)
//   avm_read        out  read strobe
//   avm_readdata    in   [31:0] slave read data
//   avm_waitrequest in   slave stall
//   busy            out  check in progress
//   done            out  one-cycle pulse at the end of every check
//   pass            out  sticky: last check matched both words
//   error_timeout   out  sticky: last check aborted on a stalled read
//   id_value        out  [31:0] last captured word 0
//   ts_value        out  [31:0] last captured word 1
//   retry_count     out  [3:0] retries consumed by the last check
// -----------------------------------------------------------------------------
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        error_timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic       ZERO_LAT    = (READ_LATENCY == 32'd0);

    state_t      state_r;
    state_t      next_state_s;

    logic        avm_read_r;
    logic        avm_address_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic        timeout_r;
    logic [31:0] id_r;
    logic [31:0] ts_r;
    logic [3:0]  retry_r;

    logic        pass_nxt_s;
    logic        timeout_nxt_s;
    logic [31:0] id_nxt_s;
    logic [31:0] ts_nxt_s;
    logic [3:0]  retry_nxt_s;

    logic        start_s;
    logic        in_read_s;
    logic        in_lat_s;
    logic        timer_run_s;
    logic        timer_clear_s;
    logic        expired_s;
    logic        lat_done_s;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic        autostart_r;

    // One-shot: high out of reset, drops after the first clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            autostart_r <= 1'b1;
        end else begin
            autostart_r <= 1'b0;
        end
    end

    assign start_s = start | autostart_r;
`else
    assign start_s = start;
`endif

    // The counter runs while a read is stalled or while waiting out the read
    // latency; it restarts at every acceptance, at the end of every latency
    // wait and in every state that does neither.
    assign in_read_s     = is_read_state(state_r);
    assign in_lat_s      = (state_r == ST_LAT_ID) || (state_r == ST_LAT_TS);
    assign timer_run_s   = (in_read_s && avm_waitrequest) || in_lat_s;
    assign timer_clear_s = !timer_run_s || (in_lat_s && lat_done_s);

    avm_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .READ_LATENCY   (READ_LATENCY)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear_s),
        .run      (timer_run_s),
        .expired  (expired_s),
        .lat_done (lat_done_s)
    );

    // Next-state and next-status decode.
    always_comb begin
        next_state_s  = state_r;
        pass_nxt_s    = pass_r;
        timeout_nxt_s = timeout_r;
        id_nxt_s      = id_r;
        ts_nxt_s      = ts_r;
        retry_nxt_s   = retry_r;

        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    pass_nxt_s    = 1'b0;
                    timeout_nxt_s = 1'b0;
                    retry_nxt_s   = 4'd0;
                    next_state_s  = ST_RD_ID;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end

            ST_RD_ID: begin
                if (avm_waitrequest) begin
                    if (expired_s) begin
                        timeout_nxt_s = 1'b1;
                        next_state_s  = ST_FINISH;
                    end else begin
                        next_state_s  = ST_RD_ID;
                    end
                end else if (ZERO_LAT) begin
                    id_nxt_s     = avm_readdata;
                    next_state_s = ST_RD_TS;
                end else begin
                    next_state_s = ST_LAT_ID;
                end
            end

            ST_LAT_ID: begin
                if (lat_done_s) begin
                    id_nxt_s     = avm_readdata;
                    next_state_s = ST_RD_TS;
                end else begin
                    next_state_s = ST_LAT_ID;
                end
            end

            ST_RD_TS: begin
                if (avm_waitrequest) begin
                    if (expired_s) begin
                        timeout_nxt_s = 1'b1;
                        next_state_s  = ST_FINISH;
                    end else begin
                        next_state_s  = ST_RD_TS;
                    end
                end else if (ZERO_LAT) begin
                    ts_nxt_s     = avm_readdata;
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_LAT_TS;
                end
            end

            ST_LAT_TS: begin
                if (lat_done_s) begin
                    ts_nxt_s     = avm_readdata;
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_LAT_TS;
                end
            end

            ST_CHECK: begin
                if (words_match(id_r, ts_r, EXPECTED_ID, EXPECTED_TS)) begin
                    pass_nxt_s   = 1'b1;
                    next_state_s = ST_FINISH;
                end else if (retry_r < RETRY_LIMIT) begin
                    retry_nxt_s  = retry_r + 4'd1;
                    next_state_s = ST_RD_ID;
                end else begin
                    pass_nxt_s   = 1'b0;
                    next_state_s = ST_FINISH;
                end
            end

            ST_FINISH: begin
                next_state_s = ST_IDLE;
            end

            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, status and output registers. Bus and handshake outputs are
    // decoded from the next state so they change together with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            avm_read_r    <= 1'b0;
            avm_address_r <= ADDR_ID;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            id_r          <= 32'd0;
            ts_r          <= 32'd0;
            retry_r       <= 4'd0;
        end else begin
            state_r       <= next_state_s;
            avm_read_r    <= is_read_state(next_state_s);
            avm_address_r <= (next_state_s == ST_RD_TS) ? ADDR_TS : ADDR_ID;
            busy_r        <= (next_state_s != ST_IDLE);
            done_r        <= (next_state_s == ST_FINISH);
            pass_r        <= pass_nxt_s;
            timeout_r     <= timeout_nxt_s;
            id_r          <= id_nxt_s;
            ts_r          <= ts_nxt_s;
            retry_r       <= retry_nxt_s;
        end
    end

    assign avm_read      = avm_read_r;
    assign avm_address   = avm_address_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign error_timeout = timeout_r;
    assign id_value      = id_r;
    assign ts_value      = ts_r;
    assign retry_count   = retry_r;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Two controller instances share clock and reset:
//   u_dut0 : default parameters, zero-wait slave with programmable word 1
//   u_dut1 : READ_LATENCY=2, TIMEOUT_CYCLES=10, slave with 3 wait states per
//            read and data valid only in the capture cycle (garbage otherwise)
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1428568153;
    localparam logic [31:0] GARB   = 32'hDEADBEEF;
    localparam logic [31:0] BAD_TS = 32'h12345678;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // dut0 signals
    logic        start0 = 1'b0;
    logic        addr0, read0, wr0, busy0, done0, pass0, tmo0;
    logic [31:0] rdata0, id0, ts0;
    logic [3:0]  retry0;
    logic [31:0] ts_resp0 = EXP_TS;

    // dut1 signals
    logic        start1 = 1'b0;
    logic        addr1, read1, busy1, done1, pass1, tmo1;
    logic        wr1 = 1'b0;
    logic [31:0] rdata1 = GARB;
    logic [31:0] id1, ts1;
    logic [3:0]  retry1;
    logic        stall1 = 1'b0;

    int checks = 0;
    int errors = 0;

    // monitors
    int rd_cycles0 = 0;
    int ts_reads0  = 0;
    int done_cnt0  = 0;

    sysid_check_ctrl u_dut0 (
        .clock           (clk),
        .reset           (rst),
        .start           (start0),
        .avm_address     (addr0),
        .avm_read        (read0),
        .avm_readdata    (rdata0),
        .avm_waitrequest (wr0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .error_timeout   (tmo0),
        .id_value        (id0),
        .ts_value        (ts0),
        .retry_count     (retry0)
    );

    sysid_check_ctrl #(
        .READ_LATENCY   (2),
        .TIMEOUT_CYCLES (10)
    ) u_dut1 (
        .clock           (clk),
        .reset           (rst),
        .start           (start1),
        .avm_address     (addr1),
        .avm_read        (read1),
        .avm_readdata    (rdata1),
        .avm_waitrequest (wr1),
        .busy            (busy1),
        .done            (done1),
        .pass            (pass1),
        .error_timeout   (tmo1),
        .id_value        (id1),
        .ts_value        (ts1),
        .retry_count     (retry1)
    );

    // zero-latency slave for dut0
    assign rdata0 = addr0 ? ts_resp0 : EXP_ID;

    // slave for dut1: 3 wait states, data valid 2 cycles after acceptance
    int   wcnt1 = 0;
    int   cd1   = 0;
    logic pend_addr1 = 1'b0;

    always @(negedge clk) begin
        if (cd1 > 0) begin
            cd1    = cd1 - 1;
            rdata1 = (cd1 == 0) ? (pend_addr1 ? EXP_TS : EXP_ID) : GARB;
        end else begin
            rdata1 = GARB;
        end
        if (rst) begin
            wr1   = 1'b0;
            wcnt1 = 0;
            cd1   = 0;
        end else if (stall1) begin
            wr1   = 1'b1;
            wcnt1 = 0;
        end else if (read1) begin
            if (wcnt1 < 3) begin
                wr1   = 1'b1;
                wcnt1 = wcnt1 + 1;
            end else begin
                wr1        = 1'b0;
                wcnt1      = 0;
                cd1        = 2;
                pend_addr1 = addr1;
            end
        end else begin
            wr1   = 1'b0;
            wcnt1 = 0;
        end
    end

    always @(negedge clk) begin
        if (read0) rd_cycles0 = rd_cycles0 + 1;
        if (read0 && addr0) ts_reads0 = ts_reads0 + 1;
        if (done0) done_cnt0 = done_cnt0 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic post_reset();
`ifdef SYSID_CHECK_AUTOSTART_EN
        step();
        check("auto_busy0", 32'(busy0), 32'd1);
        check("auto_busy1", 32'(busy1), 32'd1);
        wait_done(0, 60, "auto_done0");
        wait_done(1, 60, "auto_done1");
        check("auto_pass0", 32'(pass0), 32'd1);
        check("auto_pass1", 32'(pass1), 32'd1);
        step();
        step();
`else
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy0 || busy1) bad = bad + 1;
        end
        check("no_autostart", 32'(bad), 32'd0);
`endif
    endtask

    initial begin
        int snap_rd, snap_ts, snap_done;
        bit hold_ok;

        wr0 = 1'b0;
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0",  32'(busy0),  32'd0);
        check("rst_done0",  32'(done0),  32'd0);
        check("rst_pass0",  32'(pass0),  32'd0);
        check("rst_tmo0",   32'(tmo0),   32'd0);
        check("rst_read0",  32'(read0),  32'd0);
        check("rst_addr0",  32'(addr0),  32'd0);
        check("rst_id0",    id0,         32'd0);
        check("rst_ts0",    ts0,         32'd0);
        check("rst_retry0", 32'(retry0), 32'd0);
        check("rst_busy1",  32'(busy1),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        post_reset();

        // ---------------- timestamp mismatch, retries ----------------
        ts_resp0  = BAD_TS;
        snap_ts   = ts_reads0;
        snap_done = done_cnt0;
        start0 = 1'b1; step(); start0 = 1'b0;
        step();
        start0 = 1'b1; step(); start0 = 1'b0;   // must be ignored while busy
        wait_done(0, 60, "mm_done");
        check("mm_pass",  32'(pass0),  32'd0);
        check("mm_retry", 32'(retry0), 32'd3);
        check("mm_ts",    ts0,         BAD_TS);
        check("mm_tmo",   32'(tmo0),   32'd0);
        step();
        step();
        check("mm_pairs", 32'(ts_reads0 - snap_ts), 32'd4);
        check("mm_dones", 32'(done_cnt0 - snap_done), 32'd1);

        // ---------------- matching slave, exact timing ----------------
        ts_resp0 = EXP_TS;
        snap_rd  = rd_cycles0;
        start0 = 1'b1; step(); start0 = 1'b0;
        check("m_c1_read", 32'(read0), 32'd1);
        check("m_c1_addr", 32'(addr0), 32'd0);
        check("m_c1_busy", 32'(busy0), 32'd1);
        step();
        check("m_c2_read", 32'(read0), 32'd1);
        check("m_c2_addr", 32'(addr0), 32'd1);
        step();
        check("m_c3_read", 32'(read0), 32'd0);
        check("m_c3_done", 32'(done0), 32'd0);
        step();
        check("m_c4_done",  32'(done0),  32'd1);
        check("m_c4_pass",  32'(pass0),  32'd1);
        check("m_c4_retry", 32'(retry0), 32'd0);
        check("m_c4_ts",    ts0,         EXP_TS);
        check("m_c4_id",    id0,         EXP_ID);
        step();
        check("m_c5_done", 32'(done0), 32'd0);
        check("m_c5_busy", 32'(busy0), 32'd0);
        step();
        check("m_rd_cycles", 32'(rd_cycles0 - snap_rd), 32'd2);

        // ---------------- stall timeout on dut1 ----------------
        stall1 = 1'b1;
        start1 = 1'b1; step(); start1 = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(read1 === 1'b1 && addr1 === 1'b0)) hold_ok = 1'b0;
            step();
        end
        check("to_hold", 32'(hold_ok), 32'd1);
        check("to_done", 32'(done1),   32'd1);
        check("to_flag", 32'(tmo1),    32'd1);
        check("to_read", 32'(read1),   32'd0);
        check("to_pass", 32'(pass1),   32'd0);
        step();
        check("to_idle", 32'(busy1), 32'd0);
        check("to_keep", 32'(tmo1),  32'd1);
        stall1 = 1'b0;
        step();

        // ---------------- latency 2, 3 wait states ----------------
        start1 = 1'b1; step(); start1 = 1'b0;
        wait_done(1, 60, "lat_done");
        check("lat_pass",  32'(pass1),  32'd1);
        check("lat_tmo",   32'(tmo1),   32'd0);
        check("lat_retry", 32'(retry1), 32'd0);
        check("lat_id",    id1,         EXP_ID);
        check("lat_ts",    ts1,         EXP_TS);
        step();
        step();

        // ---------------- reset during LAT_TS ----------------
        wr0    = 1'b1;                          // dut0 parks in a stalled read
        start0 = 1'b1;
        start1 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (10) step();                     // dut1 now in LAT_TS
        check("mr_busy1_pre", 32'(busy1), 32'd1);
        check("mr_ts1_keep",  ts1,        EXP_TS);
        check("mr_read0_pre", 32'(read0), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mr_busy1", 32'(busy1), 32'd0);
        check("mr_ts1",   ts1,        32'd0);
        check("mr_read0", 32'(read0), 32'd0);
        check("mr_busy0", 32'(busy0), 32'd0);
        check("mr_pass0", 32'(pass0), 32'd0);
        check("mr_ts0",   ts0,        32'd0);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        wr0 = 1'b0;
        post_reset();

        start1 = 1'b1; step(); start1 = 1'b0;
        wait_done(1, 60, "re_done1");
        check("re_pass1", 32'(pass1), 32'd1);
        step();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_done(0, 20, "re_done0");
        check("re_pass0", 32'(pass0), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
